arb_mux: RTL

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 94 +++++++++
 1 files changed

// File: rtl/arb_mux.sv
// N-channel arbitrating multiplexer: fixed-priority or round-robin grant feeding
// a single registered output word with valid/ready handshaking on both sides.
module arb_mux #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int MODE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CHW = $clog2(N);

    logic [CHW-1:0]   ptr;
    logic [CHW-1:0]   base;
    logic [CHW-1:0]   idx;
    logic [CHW-1:0]   gidx;
    logic [N-1:0]     grant;
    logic             found;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] data_p1;
    logic [CHW-1:0]   chan_p1;
    logic             vld_p1;

    // Channel index p+k modulo N, for k in 0..N-1.
    function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return s[CHW-1:0];
    endfunction

    // ---- stage p0: arbitration and input handshake (combinational) ----
    assign base = (MODE == 0) ? '0 : ptr;
    assign load = ~vld_p1 | out_ready;

    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = wrap_add(base, k);
            if (!found && in_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Gated by rst_n so no channel sees an accept while reset is held.
    assign in_ready = grant & {N{load & rst_n}};

    // ---- stage p1: output register and round-robin pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            chan_p1 <= '0;
            vld_p1  <= 1'b0;
            ptr     <= '0;
        end else if (load) begin
            if (found) begin
                data_p1 <= sel_data;
                chan_p1 <= gidx;
                vld_p1  <= 1'b1;
                if (MODE == 1) ptr <= wrap_add(gidx, 1);
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_data  = data_p1;
    assign out_chan  = chan_p1;
    assign out_valid = vld_p1;

endmodule
